// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the EX stage and the mul/div sequencer.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_by_zero;

    // EX-stage side: issues operations, observes stall and results.
    modport master (
        output start, alu_ctrl, op_a, op_b, flush,
        input  stall, busy, done, result_lo, result_hi, div_by_zero
    );

    // Sequencer side.
    modport slave (
        input  start, alu_ctrl, op_a, op_b, flush,
        output stall, busy, done, result_lo, result_hi, div_by_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned shift-add multiplier / restoring divider that stalls
// the pipeline for WIDTH cycles while it works.
module muldiv_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter logic [3:0]  OP_MUL = 4'd5,
    parameter logic [3:0]  OP_DIV = 4'd4
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned    CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic               dbz_q, dbz_d;

    logic               is_mul_op;
    logic               is_div_op;
    logic               accept;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] step;

    // Launch decode; flush and reset both veto a new operation.
    always_comb begin
        is_mul_op = (bus.alu_ctrl == OP_MUL);
        is_div_op = (bus.alu_ctrl == OP_DIV);
        accept    = (state_q == IDLE) && bus.start && (is_mul_op || is_div_op)
                    && !bus.flush && !reset;
    end

    // One iteration of the datapath. acc holds {hi, lo}:
    // multiply: {partial product, remaining multiplier bits}, shifted right;
    // divide:   {partial remainder, dividend/quotient bits}, shifted left.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = (div_part >= {1'b0, opnd_q});
        div_diff = div_part - {1'b0, opnd_q};
        if (is_div_q) begin
            step = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                          : {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Next-state and working-register update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_div_d = is_div_op;
                    if (is_div_op && (bus.op_b == '0)) begin
                        state_d  = DONE;
                        res_lo_d = '1;
                        res_hi_d = bus.op_a;
                        dbz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = '0;
                        opnd_d  = is_div_op ? bus.op_b : bus.op_a;
                        acc_d   = {{WIDTH{1'b0}}, (is_div_op ? bus.op_a : bus.op_b)};
                    end
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step;
                    if (cnt_q == LAST_CNT) begin
                        state_d  = DONE;
                        res_lo_d = step[WIDTH-1:0];
                        res_hi_d = step[2*WIDTH-1:WIDTH];
                        dbz_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.stall       = accept || (state_q == RUN);
    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.result_lo   = res_lo_q;
    assign bus.result_hi   = res_hi_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, random ops against
// an arithmetic model, and hand-written flush/reset/ignore sequences.
module tb_muldiv_sequencer;
    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_DIV = 4'd4;

    logic clk;
    logic reset;
    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] prev_lo;
    logic [31:0] prev_hi;
    logic        prev_dbz;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        int          inj;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain unsigned arithmetic.
    task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi, output logic dbz);
        logic [63:0] p;
        if (c == OP_MUL) begin
            p   = 64'(a) * 64'(b);
            lo  = p[31:0];
            hi  = p[63:32];
            dbz = 1'b0;
        end else if (b == 32'd0) begin
            lo  = 32'hFFFF_FFFF;
            hi  = a;
            dbz = 1'b1;
        end else begin
            lo  = a / b;
            hi  = a % b;
            dbz = 1'b0;
        end
    endtask

    // Issue one op at cycle 0, optionally pulse a stray start at cycle inj,
    // and check stall/busy per cycle, latency and results.
    task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi,
                          input logic edbz, input int inj);
        int lat_exp;
        int lat;
        bit stall_ok;
        bit busy_ok;
        lat_exp  = (ctrl == OP_DIV && b == 32'd0) ? 1 : 33;
        lat      = 0;
        stall_ok = 1'b1;
        busy_ok  = 1'b1;
        bus.start    = 1'b1;
        bus.alu_ctrl = ctrl;
        bus.op_a     = a;
        bus.op_b     = b;
        @(negedge clk);
        if (bus.stall !== 1'b1) stall_ok = 1'b0;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        next_cycle();
        for (int k = 1; k <= 40; k++) begin
            if (k == inj) begin
                bus.start = 1'b1;
                bus.op_a  = $urandom;
                bus.op_b  = $urandom_range(1, 1000);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            next_cycle();
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(lat_exp));
        check({tag, " stall_during"}, 64'(stall_ok), 64'd1);
        check({tag, " busy_during"}, 64'(busy_ok), 64'd1);
        check({tag, " stall_at_done"}, 64'(bus.stall), 64'd0);
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, " result_lo"}, 64'(bus.result_lo), 64'(elo));
        check({tag, " result_hi"}, 64'(bus.result_hi), 64'(ehi));
        check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(edbz));
        next_cycle();
        @(negedge clk);
        check({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
        next_cycle();
        prev_lo  = elo;
        prev_hi  = ehi;
        prev_dbz = edbz;
    endtask

    task automatic launch(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        bus.start    = 1'b1;
        bus.alu_ctrl = ctrl;
        bus.op_a     = a;
        bus.op_b     = b;
        next_cycle();
        bus.start = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb, rlo, rhi;
        logic        rdbz;
        logic [3:0]  rc;
        bit          saw_done;
        int          lat;

        vecs[0] = '{OP_MUL, 32'd6,          32'd7,          32'd42,         32'd0,          1'b0, 0};
        vecs[1] = '{OP_MUL, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0};
        vecs[2] = '{OP_DIV, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 5};
        vecs[3] = '{OP_DIV, 32'd5,          32'd0,          32'hFFFF_FFFF, 32'd5,          1'b1, 0};
        vecs[4] = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 0};
        vecs[5] = '{OP_DIV, 32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 0};
        vecs[6] = '{OP_DIV, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0,          1'b0, 20};
        vecs[7] = '{OP_MUL, 32'd0,          32'd12345,      32'd0,          32'd0,          1'b0, 0};
        vecs[8] = '{OP_DIV, 32'h8000_0000, 32'h10,         32'h0800_0000, 32'd0,          1'b0, 0};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.alu_ctrl = 4'd0;
        bus.op_a     = 32'd0;
        bus.op_b     = 32'd0;
        bus.flush    = 1'b0;
        #12;
        check("reset stall", 64'(bus.stall), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset lo_hi", {bus.result_hi, bus.result_lo}, 64'd0);
        check("reset dbz", 64'(bus.div_by_zero), 64'd0);
        next_cycle();
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b,
                   vecs[i].lo, vecs[i].hi, vecs[i].dbz, vecs[i].inj);

        // Non-mul/div control code is ignored, then a mul right after works.
        bus.start    = 1'b1;
        bus.alu_ctrl = 4'd2;
        bus.op_a     = 32'd9;
        bus.op_b     = 32'd9;
        @(negedge clk);
        check("ignore stall", 64'(bus.stall), 64'd0);
        check("ignore busy", 64'(bus.busy), 64'd0);
        next_cycle();
        bus.start = 1'b0;
        @(negedge clk);
        check("ignore busy_next", 64'(bus.busy), 64'd0);
        check("ignore done_next", 64'(bus.done), 64'd0);
        next_cycle();
        run_op("after_ignore", OP_MUL, 32'd11, 32'd13, 32'd143, 32'd0, 1'b0, 0);

        // Flush together with an accept in IDLE: flush wins.
        bus.start    = 1'b1;
        bus.alu_ctrl = OP_MUL;
        bus.flush    = 1'b1;
        @(negedge clk);
        check("flush_accept stall", 64'(bus.stall), 64'd0);
        next_cycle();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_accept busy", 64'(bus.busy), 64'd0);
        next_cycle();

        // Start presented during DONE is taken only in the following IDLE cycle.
        launch(OP_MUL, 32'd2, 32'd2);
        repeat (32) next_cycle();
        bus.start    = 1'b1;
        bus.alu_ctrl = OP_MUL;
        bus.op_a     = 32'd9;
        bus.op_b     = 32'd9;
        @(negedge clk);
        check("done_start done", 64'(bus.done), 64'd1);
        check("done_start stall", 64'(bus.stall), 64'd0);
        check("done_start lo", 64'(bus.result_lo), 64'd4);
        next_cycle();
        @(negedge clk);
        check("idle_accept stall", 64'(bus.stall), 64'd1);
        next_cycle();
        bus.start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("idle_accept latency", 64'(lat), 64'd33);
        check("idle_accept lo", 64'(bus.result_lo), 64'd81);
        next_cycle();
        next_cycle();
        prev_lo  = 32'd81;
        prev_hi  = 32'd0;
        prev_dbz = 1'b0;

        // Randomized ops against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            rc = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            model(rc, ra, rb, rlo, rhi, rdbz);
            run_op($sformatf("rand%0d", i), rc, ra, rb, rlo, rhi, rdbz,
                   int'($urandom_range(0, 40)));
        end

        // Flush mid-run: back to IDLE, no done, results untouched.
        launch(OP_MUL, 32'd3, 32'd3);
        repeat (9) next_cycle();
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush busy", 64'(bus.busy), 64'd0);
        check("flush stall", 64'(bus.stall), 64'd0);
        check("flush done", 64'(bus.done), 64'd0);
        saw_done = 1'b0;
        repeat (35) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        check("flush no_done", 64'(saw_done), 64'd0);
        check("flush lo_kept", 64'(bus.result_lo), 64'(prev_lo));
        check("flush hi_kept", 64'(bus.result_hi), 64'(prev_hi));
        check("flush dbz_kept", 64'(bus.div_by_zero), 64'(prev_dbz));
        next_cycle();

        // Asynchronous reset mid-run clears everything at once.
        launch(OP_MUL, 32'd3, 32'd3);
        repeat (9) next_cycle();
        #2;
        reset = 1'b1;
        #1;
        check("areset stall", 64'(bus.stall), 64'd0);
        check("areset busy", 64'(bus.busy), 64'd0);
        check("areset done", 64'(bus.done), 64'd0);
        check("areset lo_hi", {bus.result_hi, bus.result_lo}, 64'd0);
        check("areset dbz", 64'(bus.div_by_zero), 64'd0);
        next_cycle();
        reset = 1'b0;
        run_op("post_reset", OP_MUL, 32'd3, 32'd3, 32'd9, 32'd0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
